i2c_reg_target: RTL and testbench
=================================

# i2c_reg_target

I2C target (responder) exposing a small 8-bit register file to an external I2C controller. It sits on the shared `scl`/`sda` bus next to the team's I2C controller and lets a remote controller program and read back local configuration registers. Fabric logic reads the registers through a side port and is notified of each bus write.

## Interface

- `TARGET_ADDR`, 7'h50: 7-bit bus address this block answers to.
- `NREGS`, 4: number of 8-bit registers, a power of two, 2..256. `AW = log2(NREGS)`.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `scl` input 1: bus clock, never driven by this block.
- `sda` inout 1: bus data, open-drain; block drives `1'b0` or `1'bz` only.
- `host_sel` input AW: register index for side-port read.
- `host_rdata` output 8: `reg[host_sel]`, combinational.
- `wr_pulse` output 1: one-cycle strobe per register written from the bus.
- `wr_idx` output AW: index written, valid with `wr_pulse`.
- `wr_data` output 8: byte written, valid with `wr_pulse`.
- `busy` output 1: high from an addressed START until STOP.

## Operation

- `scl`/`sda` pass through 2-flop synchronizers; edges come from synchronized samples. START is `sda` falling while `scl` is high. STOP is `sda` rising while `scl` is high.
- Bits are shifted MSB first and sampled on the SCL rising edge. The block changes its `sda` drive only after an SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START from any state clears the bit counter and goes to ADDR; this covers repeated START. STOP from any state releases `sda` and goes to IDLE.
- ADDR collects 8 bits. If the address matches `TARGET_ADDR`, go to ADDR_ACK and drive ACK low for 1 SCL period. Otherwise go to IGNORE with `sda` released (NACK).
- ADDR_ACK exit:
  - R/W=0 goes to PTR.
  - R/W=1 loads `reg[ptr]` into the shift register, increments `ptr`, and goes to RDATA.
- PTR: the byte's low AW bits load `ptr`; upper bits are ignored. ACK, then go to WDATA.
- WDATA: each byte is written to `reg[ptr]`, ACKed, and `ptr` increments. The block pulses `wr_pulse` with `wr_idx` equal to the pre-increment `ptr`.
- RDATA: drive 8 bits, then release `sda` and sample the controller's ACK in RDATA_ACK.
  - ACK (0): load the next register, increment `ptr`, and continue in RDATA.
  - NACK (1): go to IGNORE.
- `ptr` wraps from NREGS-1 to 0. `ptr` persists across transactions and is cleared only by reset.
- `busy` is set on address match and cleared on STOP or on entering IGNORE.

## Timing

- Reset values: all registers 0x00, `ptr`=0, `sda` released (z), `wr_pulse`=0, `wr_idx`=0, `wr_data`=0, `busy`=0, state IDLE. Asserting reset mid-transfer releases `sda` asynchronously.
- Edge detection latency is 3 clk (2 sync stages plus 1 edge register). `clk` must be at least 16× SCL.
- `sda` drive updates exactly 1 clk after a detected SCL falling edge.
- `wr_pulse` asserts 1 clk after the 8th data bit is sampled. The register updates in that same cycle, so `host_rdata` reflects the new value on the next clk.
- A START or STOP detected while in ADDR_ACK, PTR_ACK, or WDATA_ACK aborts the transfer. A partially shifted byte is discarded, with no write and no pulse.

## Configuration

- `I2C_TGT_GENERAL_CALL_EN` defined: address 0x00 with W is ACKed. Its data bytes are ACKed and discarded, with no register write, no `wr_pulse`, and no `ptr` change. Address 0x00 with R is NACKed.
- Undefined: address 0x00 is NACKed like any mismatch.

## Test plan

- Write 0xA0, 0x01, 0x11, 0x22, STOP → all 4 bytes ACKed; reg1=0x11, reg2=0x22; two `wr_pulse` with (`wr_idx`,`wr_data`) = (1,0x11), (2,0x22); `busy` falls after STOP.
- Write 0xA0, 0x01, then repeated START, 0xA1, read 2 bytes (controller ACK, then NACK) → reads 0x11, 0x22; `sda` released after the 2nd byte; `ptr`=3.
- Write 0xA2, 0x55 → address NACKed; no `wr_pulse`; registers unchanged; `busy` stays 0.
- Write 0xA0, 0x03, 0xAA, 0xBB → reg3=0xAA, reg0=0xBB (wrap); `ptr`=1.
- Assert reset during bit 4 of a data byte → `sda` z immediately; all registers 0x00; a fresh write 0xA0, 0x00, 0x7E succeeds with reg0=0x7E.
- Write 0x00, 0x06 → ACKed with the macro defined (no `wr_pulse`), NACKed without it.

Source files
------------

// File: rtl/i2c_reg_target.sv
// ---------------------------------------------------------------------------
// i2c_reg_target
//
// I2C target that exposes a small file of 8-bit registers to a remote
// controller. The controller first writes a register pointer and can then
// write data bytes or, after a repeated START with R/W=1, read bytes back.
// The pointer auto-increments, wraps at NREGS, and persists across
// transactions. Fabric logic reads registers through a side port and sees a
// one-cycle strobe for every register written from the bus.
//
// Optional feature macro: I2C_TGT_GENERAL_CALL_EN
//   defined   : address 0x00 with W is ACKed; its data bytes are ACKed and
//               dropped (no write, no strobe, no pointer change).
//   undefined : address 0x00 is NACKed like any other mismatch.
//
// Parameters
//   TARGET_ADDR : 7-bit bus address this block answers to
//   NREGS       : number of registers (power of two, 2..256)
//
// Ports
//   clk        in   system clock, rising edge (>= 16x SCL)
//   reset      in   asynchronous active-low reset
//   scl        in   bus clock (never driven here)
//   sda        io   bus data, open-drain (drives 0 or z only)
//   host_sel   in   side-port register index
//   host_rdata out  reg[host_sel], combinational
//   wr_pulse   out  one-cycle strobe per bus register write
//   wr_idx     out  register index written, valid with wr_pulse
//   wr_data    out  byte written, valid with wr_pulse
//   busy       out  high from an addressed START until STOP / IGNORE
// ---------------------------------------------------------------------------
module i2c_reg_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NREGS       = 4,
  localparam int        AW          = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl,
  inout  wire           sda,
  input  logic [AW-1:0] host_sel,
  output logic [7:0]    host_rdata,
  output logic          wr_pulse,
  output logic [AW-1:0] wr_idx,
  output logic [7:0]    wr_data,
  output logic          busy
);

`ifdef I2C_TGT_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  // Synchronizer and edge-detect registers
  logic [1:0] scl_sync_r, sda_sync_r;
  logic       scl_d_r, sda_d_r;
  logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  // FSM state and datapath registers
  state_t          state_r, state_n;
  logic [3:0]      cnt_r, cnt_n;
  logic [7:0]      shift_r, shift_n;
  logic [AW-1:0]   ptr_r, ptr_n;
  logic            rw_r, rw_n;
  logic            gc_r, gc_n;
  logic            oe_r, oe_n;
  logic            busy_r, busy_n;
  logic            wr_pulse_r, wr_pulse_n;
  logic [AW-1:0]   wr_idx_r, wr_idx_n;
  logic [7:0]      wr_data_r, wr_data_n;
  logic            we_s;
  logic [7:0]      byte_s;
  logic [7:0]      rd_byte_s;
  logic [7:0]      regs_r [NREGS];

  // Bus is released to idle-high during reset so no false edge follows it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl};
      sda_sync_r <= {sda_sync_r[0], sda};
      scl_d_r    <= scl_sync_r[1];
      sda_d_r    <= sda_sync_r[1];
    end
  end

  // Edge and bus-condition decode from synchronized samples
  always_comb begin
    scl_s      = scl_sync_r[1];
    sda_s      = sda_sync_r[1];
    scl_rise_s = scl_s & ~scl_d_r;
    scl_fall_s = ~scl_s & scl_d_r;
    // START/STOP need SCL stable high across both samples
    start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
    stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
    byte_s     = {shift_r[6:0], sda_s};
    rd_byte_s  = regs_r[ptr_r];
  end

  // FSM next-state and datapath next values
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    shift_n    = shift_r;
    ptr_n      = ptr_r;
    rw_n       = rw_r;
    gc_n       = gc_r;
    oe_n       = oe_r;
    busy_n     = busy_r;
    wr_pulse_n = 1'b0;
    wr_idx_n   = wr_idx_r;
    wr_data_n  = wr_data_r;
    we_s       = 1'b0;

    case (state_r)
      S_IDLE, S_IGNORE: begin
        oe_n = 1'b0;
      end

      // Byte reception: sample on SCL rise, act on the 8th bit
      S_ADDR, S_PTR, S_WDATA: begin
        if (scl_rise_s) begin
          shift_n = byte_s;
          cnt_n   = cnt_r + 4'd1;
          if (cnt_r == 4'd7) begin
            cnt_n = 4'd0;
            case (state_r)
              S_ADDR: begin
                if (byte_s[7:1] == TARGET_ADDR) begin
                  state_n = S_ADDR_ACK;
                  busy_n  = 1'b1;
                  rw_n    = byte_s[0];
                  gc_n    = 1'b0;
                end else if (GC_EN && (byte_s == 8'h00)) begin
                  state_n = S_ADDR_ACK;
                  busy_n  = 1'b1;
                  rw_n    = 1'b0;
                  gc_n    = 1'b1;
                end else begin
                  state_n = S_IGNORE;
                  busy_n  = 1'b0;
                end
              end
              S_PTR: begin
                if (!gc_r) begin
                  ptr_n = byte_s[AW-1:0];
                end else begin
                  ptr_n = ptr_r;
                end
                state_n = S_PTR_ACK;
              end
              default: begin
                if (!gc_r) begin
                  we_s       = 1'b1;
                  wr_pulse_n = 1'b1;
                  wr_idx_n   = ptr_r;
                  wr_data_n  = byte_s;
                  ptr_n      = ptr_r + AW'(1);
                end else begin
                  we_s = 1'b0;
                end
                state_n = S_WDATA_ACK;
              end
            endcase
          end else begin
            state_n = state_r;
          end
        end else begin
          shift_n = shift_r;
        end
      end

      // Our ACK slot: first SCL fall starts the drive, second ends it
      S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
        if (scl_fall_s) begin
          if (cnt_r == 4'd0) begin
            oe_n  = 1'b1;
            cnt_n = 4'd1;
          end else begin
            cnt_n = 4'd0;
            oe_n  = 1'b0;
            if ((state_r == S_ADDR_ACK) && rw_r) begin
              shift_n = rd_byte_s;
              ptr_n   = ptr_r + AW'(1);
              oe_n    = ~rd_byte_s[7];
              state_n = S_RDATA;
            end else if (state_r == S_ADDR_ACK) begin
              state_n = S_PTR;
            end else begin
              state_n = S_WDATA;
            end
          end
        end else begin
          cnt_n = cnt_r;
        end
      end

      // Transmit: MSB already on the bus; shift on each fall after a rise
      S_RDATA: begin
        if (scl_rise_s) begin
          cnt_n = cnt_r + 4'd1;
        end else if (scl_fall_s) begin
          if (cnt_r == 4'd8) begin
            oe_n    = 1'b0;
            cnt_n   = 4'd0;
            state_n = S_RDATA_ACK;
          end else begin
            shift_n = {shift_r[6:0], 1'b0};
            oe_n    = ~shift_r[6];
          end
        end else begin
          cnt_n = cnt_r;
        end
      end

      // Controller ACK/NACK: NACK ends the read, ACK queues the next byte
      S_RDATA_ACK: begin
        if (scl_rise_s) begin
          if (sda_s) begin
            state_n = S_IGNORE;
            busy_n  = 1'b0;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = 4'd1;
          end
        end else if (scl_fall_s && (cnt_r == 4'd1)) begin
          cnt_n   = 4'd0;
          shift_n = rd_byte_s;
          ptr_n   = ptr_r + AW'(1);
          oe_n    = ~rd_byte_s[7];
          state_n = S_RDATA;
        end else begin
          cnt_n = cnt_r;
        end
      end

      default: begin
        state_n = S_IDLE;
        oe_n    = 1'b0;
        cnt_n   = 4'd0;
      end
    endcase

    // Bus conditions override whatever the current state decided
    if (stop_s) begin
      state_n    = S_IDLE;
      oe_n       = 1'b0;
      busy_n     = 1'b0;
      cnt_n      = 4'd0;
      we_s       = 1'b0;
      wr_pulse_n = 1'b0;
    end else if (start_s) begin
      state_n    = S_ADDR;
      oe_n       = 1'b0;
      cnt_n      = 4'd0;
      we_s       = 1'b0;
      wr_pulse_n = 1'b0;
    end else begin
      state_n = state_n;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 4'd0;
      shift_r    <= 8'h00;
      ptr_r      <= '0;
      rw_r       <= 1'b0;
      gc_r       <= 1'b0;
      oe_r       <= 1'b0;
      busy_r     <= 1'b0;
      wr_pulse_r <= 1'b0;
      wr_idx_r   <= '0;
      wr_data_r  <= 8'h00;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      shift_r    <= shift_n;
      ptr_r      <= ptr_n;
      rw_r       <= rw_n;
      gc_r       <= gc_n;
      oe_r       <= oe_n;
      busy_r     <= busy_n;
      wr_pulse_r <= wr_pulse_n;
      wr_idx_r   <= wr_idx_n;
      wr_data_r  <= wr_data_n;
    end
  end

  // Register file, updated in the same cycle the write strobe rises
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (we_s) begin
      regs_r[wr_idx_n] <= wr_data_n;
    end
  end

  assign sda        = oe_r ? 1'b0 : 1'bz;
  assign host_rdata = regs_r[host_sel];
  assign wr_pulse   = wr_pulse_r;
  assign wr_idx     = wr_idx_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: a table of bus operations with expected ACKs,
// read data, side-port values and busy level, plus a scoreboard queue of
// expected (wr_idx, wr_data) strobes and a hand-written mid-byte reset case.
module tb_i2c_reg_target;
  localparam int AW = 2;
  localparam int H  = 20;   // SCL half period in clk cycles
  localparam int Q  = 5;    // data hold after SCL fall
`ifdef I2C_TGT_GENERAL_CALL_EN
  localparam logic GC = 1'b1;
`else
  localparam logic GC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          scl = 1'b1;
  logic          sda_low = 1'b0;
  wire           sda;
  logic [AW-1:0] host_sel = '0;
  logic [7:0]    host_rdata;
  logic          wr_pulse;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_data;
  logic          busy;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_reg_target #(.TARGET_ADDR(7'h50), .NREGS(4)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .host_sel(host_sel), .host_rdata(host_rdata),
    .wr_pulse(wr_pulse), .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy)
  );

  typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RDA, OP_RDN, OP_HOST} op_t;
  typedef struct {
    op_t           op;
    logic [7:0]    data;   // byte to write / host index
    logic [7:0]    exp;    // expected ack bit (WR) / read byte / host value
    logic          busy;   // expected busy after the op
    logic          push;   // op should produce a wr_pulse
    logic [AW-1:0] pidx;   // expected wr_idx of that pulse
  } vec_t;

  vec_t           vecs[$];
  logic [AW+7:0]  exp_q[$];
  logic [AW+7:0]  obs_mem [0:63];
  int             obs_wr = 0;
  int             obs_rd = 0;
  int             n_push = 0;
  int             checks = 0;
  int             failures = 0;

  // Record every strobe seen on the write side port
  always @(negedge clk) begin
    if (reset && wr_pulse && (obs_wr < 64)) begin
      obs_mem[obs_wr] <= {wr_idx, wr_data};
      obs_wr <= obs_wr + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    while (obs_rd < obs_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr_pulse actual=%0h required=none", obs_mem[obs_rd]);
      end else begin
        chk("wr_pulse_idx_data", 32'(obs_mem[obs_rd]), 32'(exp_q.pop_front()));
      end
      obs_rd++;
    end
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; wclk(H);
    scl = 1'b1;     wclk(H);
    sda_low = 1'b1; wclk(H);
    scl = 1'b0;     wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wclk(H);
    scl = 1'b1;     wclk(H);
    sda_low = 1'b0; wclk(H);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_low = ~b; wclk(H);
    scl = 1'b1;   wclk(H/2);
    s = sda;      wclk(H/2);
    scl = 1'b0;   wclk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
    sda_low = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
    clock_bit(nack, s);
    sda_low = 1'b0;
  endtask

  task automatic add(input op_t op, input logic [7:0] d, input logic [7:0] e,
                     input logic b, input logic p, input logic [AW-1:0] pi);
    vec_t v;
    v.op = op; v.data = d; v.exp = e; v.busy = b; v.push = p; v.pidx = pi;
    vecs.push_back(v);
  endtask

  task automatic run_vecs();
    logic       a;
    logic [7:0] d;
    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_START: i2c_start();
        OP_STOP:  i2c_stop();
        OP_WR: begin
          if (vecs[i].push) begin
            exp_q.push_back({vecs[i].pidx, vecs[i].data});
            n_push++;
          end
          write_byte(vecs[i].data, a);
          chk($sformatf("row%0d_ack", i), 32'(a), 32'(vecs[i].exp[0]));
        end
        OP_RDA, OP_RDN: begin
          read_byte(vecs[i].op == OP_RDN, d);
          chk($sformatf("row%0d_rdata", i), 32'(d), 32'(vecs[i].exp));
        end
        default: begin
          host_sel = vecs[i].data[AW-1:0];
          wclk(1);
          chk($sformatf("row%0d_host_rdata", i), 32'(host_rdata), 32'(vecs[i].exp));
        end
      endcase
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      drain();
    end
    vecs.delete();
  endtask

  // Overall time limit
  initial begin
    #3000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic [2:0] bits;
    logic       s;

    // Reset state
    wclk(3);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    for (int r = 0; r < 4; r++) begin
      host_sel = AW'(r); wclk(1);
      chk($sformatf("rst_reg%0d", r), 32'(host_rdata), 32'd0);
    end
    reset = 1'b1;
    wclk(5);

    // Basic write of reg1/reg2
    add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'hA0, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_WR,    8'h01, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_WR,    8'h11, 8'h00, 1'b1, 1'b1, 2'd1);
    add(OP_WR,    8'h22, 8'h00, 1'b1, 1'b1, 2'd2);
    add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h01, 8'h11, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h02, 8'h22, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    // Pointer wrap: reg3 then reg0
    add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'hA0, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_WR,    8'h03, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_WR,    8'hAA, 8'h00, 1'b1, 1'b1, 2'd3);
    add(OP_WR,    8'hBB, 8'h00, 1'b1, 1'b1, 2'd0);
    add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h03, 8'hAA, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h00, 8'hBB, 1'b0, 1'b0, 2'd0);
    // Read without pointer: ptr was left at 1
    add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'hA1, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_RDN,   8'h00, 8'h11, 1'b0, 1'b0, 2'd0);
    add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    // Pointer write, repeated START, two-byte read
    add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'hA0, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_WR,    8'h01, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_START, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_WR,    8'hA1, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_RDA,   8'h00, 8'h11, 1'b1, 1'b0, 2'd0);
    add(OP_RDN,   8'h00, 8'h22, 1'b0, 1'b0, 2'd0);
    add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    // ptr must now be 3
    add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'hA1, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_RDN,   8'h00, 8'hAA, 1'b0, 1'b0, 2'd0);
    add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    // Wrong address: NACK, nothing written, busy stays low
    add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'hA2, 8'h01, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'h55, 8'h01, 1'b0, 1'b0, 2'd0);
    add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h00, 8'hBB, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h01, 8'h11, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h02, 8'h22, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h03, 8'hAA, 1'b0, 1'b0, 2'd0);
    // General call: ACK only when the feature is built in
    add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'h00, {7'd0, ~GC}, GC, 1'b0, 2'd0);
    add(OP_WR,    8'h06, {7'd0, ~GC}, GC, 1'b0, 2'd0);
    add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h02, 8'h22, 1'b0, 1'b0, 2'd0);
    // ptr untouched by general call: still 0
    add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'hA1, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_RDN,   8'h00, 8'hBB, 1'b0, 1'b0, 2'd0);
    add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    run_vecs();

    // Reset while the target drives bit 4 (a 0) of 0x22 in a read
    i2c_start();
    write_byte(8'hA0, a); chk("mr_addw_ack", 32'(a), 32'd0);
    write_byte(8'h02, a); chk("mr_ptr_ack", 32'(a), 32'd0);
    i2c_start();
    write_byte(8'hA1, a); chk("mr_addr_ack", 32'(a), 32'd0);
    for (int i = 2; i >= 0; i--) begin
      clock_bit(1'b1, s);
      bits[i] = s;
    end
    chk("mr_first_bits", 32'(bits), 32'h1);
    wclk(H);
    scl = 1'b1;
    wclk(H/2);
    chk("mr_driving_bit4", 32'(sda), 32'd0);
    reset = 1'b0;
    #1;
    chk("mr_sda_released", 32'(sda), 32'd1);
    wclk(2);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_wr_pulse", 32'(wr_pulse), 32'd0);
    for (int r = 0; r < 4; r++) begin
      host_sel = AW'(r); wclk(1);
      chk($sformatf("mr_reg%0d", r), 32'(host_rdata), 32'd0);
    end
    scl = 1'b0;
    wclk(H);
    reset = 1'b1;
    wclk(H);
    i2c_stop();
    drain();

    // Fresh write after reset
    add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_WR,    8'hA0, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_WR,    8'h00, 8'h00, 1'b1, 1'b0, 2'd0);
    add(OP_WR,    8'h7E, 8'h00, 1'b1, 1'b1, 2'd0);
    add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h00, 8'h7E, 1'b0, 1'b0, 2'd0);
    add(OP_HOST,  8'h02, 8'h00, 1'b0, 1'b0, 2'd0);
    run_vecs();

    wclk(4);
    drain();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("pulse_count", 32'(obs_wr), 32'(n_push));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
